// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Initiator-side master between the core MEM stage and a
//               single-port, word-wide data memory. It converts RV32I
//               LB/LH/LW/LBU/LHU/SB/SH/SW requests into whole-word accesses.
//               Sub-word stores are done as read-modify-write.
// Ports       : clk, rst_n            - clock, synchronous active-low reset
//               req_valid/req_ready   - request handshake (ready only in IDLE)
//               req_we/req_funct3/req_addr/req_wdata - request fields
//               rsp_valid/rsp_ready   - response handshake
//               rsp_rdata/rsp_err     - extended load data, error flag
//               mem_addr/mem_wdata/mem_we/mem_rdata - data memory port
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_W        = 32,
    parameter bit ERR_ZERO_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    // Latched request fields. Only the byte offset and the low half of the
    // store data are needed after acceptance; the word address lives in
    // mem_addr_q and SW data goes straight into mem_wdata_q.
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [15:0]       wdata_lo_q, wdata_lo_d;
    logic              rmw_q, rmw_d;
    logic [31:0]       rbuf_q, rbuf_d;

    logic              legal;
    logic              misaligned;

    // Lane-select and extend a loaded word.
    function automatic logic [31:0] load_ext(input logic [31:0] w,
                                             input logic [1:0]  a,
                                             input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b010:  load_ext = w;
            3'b100:  load_ext = {24'd0, b};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = 32'd0;
        endcase
    endfunction

    // Replace the addressed byte/half lane of the old word with store data.
    function automatic logic [31:0] merge(input logic [31:0] w,
                                          input logic [1:0]  a,
                                          input logic [2:0]  f3,
                                          input logic [15:0] wd);
        logic [31:0] r;
        r = w;
        if (f3 == 3'b000) begin
            r[{a, 3'b000} +: 8] = wd[7:0];
        end else if (a[1]) begin
            r[31:16] = wd;
        end else begin
            r[15:0] = wd;
        end
        merge = r;
    endfunction

    always_comb begin
        if (req_we) begin
            legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                    (req_funct3 == 3'b010);
        end else begin
            legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                    (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                    (req_funct3 == 3'b101);
        end
        // funct3[1:0] encodes access size: 01 half, 10 word.
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end

    // Outputs are registered, so each transition computes the values the
    // outputs must carry in the state being entered.
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        addr_lo_d   = addr_lo_q;
        funct3_d    = funct3_q;
        wdata_lo_d  = wdata_lo_q;
        rmw_d       = rmw_q;
        rbuf_d      = rbuf_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_lo_d   = req_addr[1:0];
                    funct3_d    = req_funct3;
                    wdata_lo_d  = req_wdata[15:0];
                    req_ready_d = 1'b0;
                    rmw_d       = 1'b0;
                    if (!legal || misaligned) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = (ERR_ZERO_DATA || req_we) ? 32'd0 :
                                      load_ext(rbuf_q, req_addr[1:0], req_funct3);
                    end else begin
                        mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                        if (!req_we) begin
                            state_d = S_RD;
                        end else if (req_funct3 == 3'b010) begin
                            state_d     = S_WR;
                            mem_we_d    = 1'b1;
                            mem_wdata_d = req_wdata;
                        end else begin
                            state_d = S_RD;
                            rmw_d   = 1'b1;
                        end
                    end
                end
            end
            S_RD: begin
                // mem_rdata is valid this cycle, so the merge/extend can use
                // it directly while it is also captured into rbuf.
                rbuf_d = mem_rdata;
                if (rmw_q) begin
                    state_d     = S_WR;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = merge(mem_rdata, addr_lo_q, funct3_q, wdata_lo_q);
                end else begin
                    state_d     = S_RESP;
                    mem_addr_d  = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = load_ext(mem_rdata, addr_lo_q, funct3_q);
                end
            end
            S_WR: begin
                state_d     = S_RESP;
                mem_we_d    = 1'b0;
                mem_addr_d  = '0;
                mem_wdata_d = 32'd0;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = 32'd0;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = 32'd0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            mem_we_q    <= 1'b0;
            addr_lo_q   <= 2'd0;
            funct3_q    <= 3'd0;
            wdata_lo_q  <= 16'd0;
            rmw_q       <= 1'b0;
            rbuf_q      <= 32'd0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            addr_lo_q   <= addr_lo_d;
            funct3_q    <= funct3_d;
            wdata_lo_q  <= wdata_lo_d;
            rmw_q       <= rmw_d;
            rbuf_q      <= rbuf_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit with a
//               behavioural word-wide data memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];
    int          wr_cnt = 0;
    logic [31:0] last_wa = 32'd0;
    logic [31:0] last_wd = 32'd0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .ERR_ZERO_DATA(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[11:2]] <= mem_wdata;
            wr_cnt  <= wr_cnt + 1;
            last_wa <= mem_addr;
            last_wd <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request, corrupt req_* after acceptance, hold the response
    // for 'hold' cycles with rsp_ready low, then complete the handshake.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int hold, input int exp_lat,
                          input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        rsp_ready = (hold == 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = ~wd; req_addr = addr ^ 32'h4; req_funct3 = 3'b010; req_we = ~we;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"},   lat,       exp_lat);
        check({tag, "_rdata"}, rsp_rdata, exp_rd);
        check({tag, "_err"},   rsp_err,   exp_err);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, rsp_valid, 1);
            check({tag, "_hold_rdata"}, rsp_rdata, exp_rd);
            check({tag, "_hold_err"},   rsp_err,   exp_err);
            check({tag, "_hold_rdy"},   req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, "_done_valid"}, rsp_valid, 0);
        check({tag, "_done_rdy"},   req_ready, 1);
    endtask

    initial begin
        int wc0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;

        // Reset held for two edges with a request pending.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h104; req_wdata = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_mem_we",    mem_we,    0);
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err",   rsp_err,   0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_req_ready", req_ready, 1);
        check("rel_mem_we",    mem_we,    0);
        check("rel_wr_cnt",    wr_cnt,    0);

        // SW then LW.
        wc0 = wr_cnt;
        do_req("sw", 1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF, 0, 2, 32'd0, 1'b0);
        check("sw_wr_cnt", wr_cnt - wc0, 1);
        check("sw_addr",   last_wa, 32'h104);
        check("sw_data",   last_wd, 32'hDEAD_BEEF);
        wc0 = wr_cnt;
        do_req("lw", 1'b0, 3'b010, 32'h104, 32'h0, 0, 2, 32'hDEAD_BEEF, 1'b0);
        check("lw_no_wr", wr_cnt - wc0, 0);

        // SB read-modify-write.
        @(negedge clk); mem[32'h104 >> 2] = 32'h1122_3344;
        wc0 = wr_cnt;
        do_req("sb", 1'b1, 3'b000, 32'h106, 32'h0000_00AA, 0, 3, 32'd0, 1'b0);
        check("sb_wr_cnt", wr_cnt - wc0, 1);
        check("sb_addr",   last_wa, 32'h104);
        check("sb_data",   last_wd, 32'h11AA_3344);
        do_req("lw_sb", 1'b0, 3'b010, 32'h104, 32'h0, 0, 2, 32'h11AA_3344, 1'b0);

        // Sub-word loads with extension.
        @(negedge clk); mem[32'h200 >> 2] = 32'h80FF_7F01;
        do_req("lb",  1'b0, 3'b000, 32'h203, 32'h0, 0, 2, 32'hFFFF_FF80, 1'b0);
        do_req("lbu", 1'b0, 3'b100, 32'h203, 32'h0, 0, 2, 32'h0000_0080, 1'b0);
        do_req("lh",  1'b0, 3'b001, 32'h202, 32'h0, 0, 2, 32'hFFFF_80FF, 1'b0);
        do_req("lhu", 1'b0, 3'b101, 32'h200, 32'h0, 0, 2, 32'h0000_7F01, 1'b0);

        // SH upper half.
        wc0 = wr_cnt;
        do_req("sh", 1'b1, 3'b001, 32'h202, 32'hFFFF_1234, 0, 3, 32'd0, 1'b0);
        check("sh_wr_cnt", wr_cnt - wc0, 1);
        check("sh_data",   last_wd, 32'h1234_7F01);

        // Error responses: misaligned and illegal funct3.
        wc0 = wr_cnt;
        do_req("sh_mis",  1'b1, 3'b001, 32'h105, 32'h5555, 0, 1, 32'd0, 1'b1);
        do_req("lw_mis",  1'b0, 3'b010, 32'h102, 32'h0,    0, 1, 32'd0, 1'b1);
        do_req("st_ill",  1'b1, 3'b011, 32'h100, 32'h7777, 0, 1, 32'd0, 1'b1);
        do_req("st_ill4", 1'b1, 3'b100, 32'h100, 32'h7777, 0, 1, 32'd0, 1'b1);
        do_req("ld_ill",  1'b0, 3'b110, 32'h200, 32'h0,    0, 1, 32'd0, 1'b1);
        check("err_no_wr", wr_cnt - wc0, 0);

        // Back-pressured load response.
        do_req("lw_bp", 1'b0, 3'b010, 32'h200, 32'h0, 3, 2, 32'h1234_7F01, 1'b0);

        // Reset during the RD cycle of an SB drops the store.
        @(negedge clk); mem[32'h300 >> 2] = 32'h5555_5555;
        req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h300;
        req_wdata = 32'h0000_00AA; req_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        wc0 = wr_cnt;
        @(posedge clk); #1;
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("rstrd_no_wr",  wr_cnt - wc0, 0);
        check("rstrd_mem",    mem[32'h300 >> 2], 32'h5555_5555);
        check("rstrd_ready",  req_ready, 1);
        check("rstrd_valid",  rsp_valid, 0);
        check("rstrd_mem_we", mem_we, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
